// File: rtl/example.sv
// Detects the ordered input-pair sequence 11 -> 01 -> 11 on {a,b}, with overlap.
// Each detection gives a one-cycle registered pulse on c and bumps the wrapping count s2.
module example #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   output logic             c,
   output logic [2:0]       s1,
   output logic [CNT_W-1:0] s2
);

   localparam logic [2:0] IDLE      = 3'b001;
   localparam logic [2:0] SEEN11    = 3'b010;
   localparam logic [2:0] SEEN11_01 = 3'b100;

   logic [1:0] pair;
   logic [2:0] state_next;
   logic       det;

   assign pair = {a, b};

   // Unknown or unlisted pairs fall through to IDLE because the equality tests
   // below never take the true branch for them.
   always_comb begin
      state_next = IDLE;
      det        = 1'b0;
      case (s1)
         IDLE: begin
            if (pair == 2'b11) state_next = SEEN11;
         end
         SEEN11: begin
            if (pair == 2'b01)      state_next = SEEN11_01;
            else if (pair == 2'b11) state_next = SEEN11;
         end
         SEEN11_01: begin
            if (pair == 2'b11) begin
               state_next = SEEN11;
               det        = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= IDLE;
         c  <= 1'b0;
         s2 <= '0;
      end else begin
         s1 <= state_next;
         c  <= det;
         if (det) s2 <= s2 + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_example.sv
// Directed-vector bench for the 11->01->11 detector; expected {c,s1,s2} per edge
// goes into a queue that an independent monitor drains after every rising edge.
module tb_example;

   localparam int CNT_W = 3;
   localparam int W     = 1 + 3 + CNT_W;

   logic             clk;
   logic             rst;
   logic             a;
   logic             b;
   logic             c;
   logic [2:0]       s1;
   logic [CNT_W-1:0] s2;

   logic [W-1:0] exp_q[$];
   int           tag_q[$];
   int           n_checks;
   int           n_fail;
   int           n_sent;
   int           n_popped;

   example #(.CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .a  (a),
      .b  (b),
      .c  (c),
      .s1 (s1),
      .s2 (s2)
   );

   // clock / reset defaults
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver: apply one input pair for the next edge and queue what that edge must produce
   task automatic step(input logic r, input logic ia, input logic ib,
                       input logic ec, input logic [2:0] es1, input logic [CNT_W-1:0] es2);
      @(negedge clk);
      rst = r;
      a   = ia;
      b   = ib;
      exp_q.push_back({ec, es1, es2});
      tag_q.push_back(n_sent);
      n_sent++;
   endtask

   // monitor / scoreboard: outputs are registered, so every edge presents a result
   initial begin
      logic [W-1:0] exp_v;
      int           tag;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            n_popped++;
            n_checks++;
            if ({c, s1, s2} !== exp_v) begin
               n_fail++;
               $display("FAIL step%0d: got c=%0b s1=%03b s2=%0d, want c=%0b s1=%03b s2=%0d",
                        tag, c, s1, s2, exp_v[W-1], exp_v[W-2 -: 3], exp_v[CNT_W-1:0]);
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_sent   = 0;
      n_popped = 0;
      rst = 1'b1;
      a   = 1'b0;
      b   = 1'b0;

      // reset for two edges with arbitrary inputs, then idle on 00
      step(1, 1, 0, 0, 3'b001, 0);
      step(1, 1, 1, 0, 3'b001, 0);
      step(0, 0, 0, 0, 3'b001, 0);
      step(0, 0, 0, 0, 3'b001, 0);

      // basic detect
      step(0, 1, 1, 0, 3'b010, 0);
      step(0, 0, 1, 0, 3'b100, 0);
      step(0, 1, 1, 1, 3'b010, 1);
      step(0, 0, 0, 0, 3'b001, 1);

      // broken: 11,00,11
      step(1, 0, 0, 0, 3'b001, 0);
      step(0, 1, 1, 0, 3'b010, 0);
      step(0, 0, 0, 0, 3'b001, 0);
      step(0, 1, 1, 0, 3'b010, 0);
      step(0, 0, 0, 0, 3'b001, 0);

      // broken: 11,01,10
      step(0, 1, 1, 0, 3'b010, 0);
      step(0, 0, 1, 0, 3'b100, 0);
      step(0, 1, 0, 0, 3'b001, 0);

      // repeated prefix: 11,11,01,11
      step(0, 1, 1, 0, 3'b010, 0);
      step(0, 1, 1, 0, 3'b010, 0);
      step(0, 0, 1, 0, 3'b100, 0);
      step(0, 1, 1, 1, 3'b010, 1);
      step(0, 0, 0, 0, 3'b001, 1);

      // overlap: 11,01,11,01,11
      step(1, 0, 0, 0, 3'b001, 0);
      step(0, 1, 1, 0, 3'b010, 0);
      step(0, 0, 1, 0, 3'b100, 0);
      step(0, 1, 1, 1, 3'b010, 1);
      step(0, 0, 1, 0, 3'b100, 1);
      step(0, 1, 1, 1, 3'b010, 2);
      step(0, 0, 0, 0, 3'b001, 2);

      // wrap: 8 overlapping detections, count 1..7 then 0
      step(1, 0, 0, 0, 3'b001, 0);
      step(0, 1, 1, 0, 3'b010, 0);
      for (int k = 1; k <= 8; k++) begin
         step(0, 0, 1, 0, 3'b100, CNT_W'(k - 1));
         step(0, 1, 1, 1, 3'b010, CNT_W'(k));
      end

      // reset on the edge that would complete a detection (count is 0 after wrap)
      step(0, 0, 1, 0, 3'b100, 0);
      step(0, 1, 1, 1, 3'b010, 1);
      step(0, 0, 1, 0, 3'b100, 1);
      step(1, 1, 1, 0, 3'b001, 0);
      step(0, 0, 0, 0, 3'b001, 0);
      step(0, 1, 1, 0, 3'b010, 0);

      // drain the scoreboard, bounded
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      n_checks++;
      if (n_popped != n_sent) begin
         n_fail++;
         $display("FAIL drain: checked %0d results, want %0d", n_popped, n_sent);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
